his_peak_reader: RTL and testbench
==================================

Name: his_peak_reader

Overview:
- Read-side counterpart of the histogram builder. It shares the dual-port histogram RAM with the builder and owns port b (read) plus the write port for clearing.
- Started by the builder's build-done pulse. It scans every bin of every pixel histogram, finds each pixel's peak bin and returns it over a valid/ready handshake.
- When clearing is enabled, it zeroes each bin as it is read, so the RAM is ready for the next acquisition.

Parameters:
- BIN_NUM, 32: bins per pixel histogram.
- PIXEL_NUM, 4: pixels (histograms) per RAM.
- CNT_W, 8: width of a bin count.
- ADDR_W, 7: RAM address width. Must satisfy 2^ADDR_W >= BIN_NUM*PIXEL_NUM.
- BIN_W, 5: width of a bin index, clog2(BIN_NUM).
- PIX_W, 2: width of a pixel index, clog2(PIXEL_NUM).
- CLEAR_EN, 1: 1 = write 0 to each bin after it is read; 0 = read-only scan.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- res  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse (the builder's build-done) that begins a scan.
- raddr  output  ADDR_W  RAM read address.
- rEnable  output  1  RAM read enable.
- rdata  input  CNT_W  RAM read data, valid 1 cycle after rEnable.
- waddr  output  ADDR_W  RAM write address (clear).
- wEnable  output  1  RAM write enable.
- wdata  output  CNT_W  RAM write data, always 0.
- busy  output  1  high from the cycle after an accepted start until done.
- peakValid  output  1  peak result valid.
- peakReady  input  1  consumer accepts the result.
- peakPixel  output  PIX_W  pixel index of the result.
- peakBin  output  BIN_W  bin index holding the maximum count.
- peakCounts  output  CNT_W  maximum count value.
- done  output  1  one-cycle pulse after the last pixel's result is accepted.

Behaviour:
- Reset: every output is 0, the FSM goes to IDLE, and the internal pixel, bin and max registers are 0. Reset mid-scan aborts immediately: no further reads or writes, and no done pulse.
- FSM states: IDLE, SCAN, LAST, PRESENT, FIN.
- IDLE:
  - start=1 → SCAN next cycle, with pixel=0, bin=0 and busy=1.
  - start while not IDLE is ignored.
- SCAN:
  - Each cycle drive raddr = pixel*BIN_NUM + bin with rEnable=1, then bin++.
  - After issuing bin BIN_NUM-1 → LAST.
- Read pipeline:
  - The address is delayed by 1 cycle alongside the data. rdata for bin k is compared in the cycle after its read.
  - For bin 0, rdata is loaded unconditionally: max=rdata, maxBin=0.
  - For k>0, if rdata > max (strictly greater): max=rdata, maxBin=k.
  - Ties therefore keep the lowest bin. An all-zero histogram reports bin 0 with count 0.
- LAST:
  - rEnable=0; the last bin's data is compared this cycle.
  - Next state is PRESENT, with peakValid=1 and the peak outputs registered from pixel, maxBin and max.
- PRESENT:
  - peakValid and the peak outputs are held stable until peakValid && peakReady.
  - On handshake, peakValid=0 in the next cycle.
  - If pixel == PIXEL_NUM-1 → FIN. Otherwise pixel++, bin=0, → SCAN.
  - No RAM access occurs while waiting.
- FIN: done=1 and busy=0 for one cycle, then → IDLE.
- Clear (CLEAR_EN=1):
  - In the cycle rdata for address A is consumed: wEnable=1, waddr=A, wdata=0.
  - Read of A+1 and write of A happen in the same cycle on different ports.
  - wEnable is never asserted for an address that was not read this scan.
  - With CLEAR_EN=0, wEnable stays 0.
- Timing with peakReady held high and a start in cycle 0:
  - SCAN occupies cycles 1..BIN_NUM; LAST is cycle BIN_NUM+1; peakValid is first high in cycle BIN_NUM+2.
  - Each pixel takes BIN_NUM+2 cycles.
  - done pulses PIXEL_NUM*(BIN_NUM+2)+1 cycles after start: cycle 137 for the defaults.
- Address arithmetic is unsigned and never wraps within a scan. The maximum address is BIN_NUM*PIXEL_NUM-1 (127).

Test Plan:
- Preload pixel0 bin 5=9 and all else 0; start; peakReady=1 → pixel 0 reports bin 5 / count 9 at cycle 34. Pixels 1–3 report bin 0 / count 0. done at cycle 137.
- Pixel2 bins 3 and 20 both = 200, bin 10 = 199 → pixel 2 reports bin 3 / count 200 (tie keeps the lowest bin).
- CLEAR_EN=1, RAM preloaded with random data; scan; then read back all 128 addresses → all 0. wEnable was asserted exactly 128 times, with waddr 0..127 in order.
- peakReady=0 for 10 cycles at pixel 1 → peakValid and the peak outputs are stable, rEnable=0 and wEnable=0 throughout. After ready rises, pixel 2's scan starts the next cycle.
- Second start pulse during SCAN → ignored: the result count stays 4 and there is one done pulse.
- res=1 at cycle 50 → next cycle all outputs 0 and the FSM is in IDLE. A new start gives a fresh scan, with the first result at start+34.

Source files
------------

// File: rtl/his_peak_reader.sv
// Histogram peak reader: scans each pixel histogram in RAM, reports its peak bin
// over valid/ready, and optionally zeroes every bin behind the read pointer.
module his_peak_reader #(
  parameter int BIN_NUM   = 32,
  parameter int PIXEL_NUM = 4,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 7,
  parameter int BIN_W     = 5,
  parameter int PIX_W     = 2,
  parameter bit CLEAR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  output logic [ADDR_W-1:0] raddr,
  output logic              rEnable,
  input  logic [CNT_W-1:0]  rdata,
  output logic [ADDR_W-1:0] waddr,
  output logic              wEnable,
  output logic [CNT_W-1:0]  wdata,
  output logic              busy,
  output logic              peakValid,
  input  logic              peakReady,
  output logic [PIX_W-1:0]  peakPixel,
  output logic [BIN_W-1:0]  peakBin,
  output logic [CNT_W-1:0]  peakCounts,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, SCAN, LAST, PRESENT, FIN
  } state_t;

  state_t state, nextState;

  logic [PIX_W-1:0]  pixel;
  logic [BIN_W-1:0]  bin;
  logic [BIN_W-1:0]  rdBin;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdValid;
  logic [CNT_W-1:0]  maxCnt, nextMax;
  logic [BIN_W-1:0]  maxBin, nextMaxBin;
  logic              lastPix;
  logic [ADDR_W-1:0] scanAddr;

  assign lastPix  = (pixel == PIX_W'(PIXEL_NUM - 1));
  assign scanAddr = ADDR_W'(pixel) * ADDR_W'(BIN_NUM)
                  + ADDR_W'(bin);

  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = SCAN;
      SCAN:    if (bin == BIN_W'(BIN_NUM - 1))
                 nextState = LAST;
      LAST:    nextState = PRESENT;
      PRESENT: if (peakReady)
                 nextState = lastPix ? FIN : SCAN;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bin 0 always seeds the running max; later bins replace it only when
  // strictly larger, so ties keep the lowest bin.
  always_comb begin
    nextMax    = maxCnt;
    nextMaxBin = maxBin;
    if (rdValid && (rdBin == '0 || rdata > maxCnt)) begin
      nextMax    = rdata;
      nextMaxBin = rdBin;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      pixel      <= '0;
      bin        <= '0;
      rdBin      <= '0;
      rdAddr     <= '0;
      rdValid    <= 1'b0;
      maxCnt     <= '0;
      maxBin     <= '0;
      peakPixel  <= '0;
      peakBin    <= '0;
      peakCounts <= '0;
    end else begin
      rdValid <= rEnable;
      rdBin   <= bin;
      rdAddr  <= scanAddr;
      maxCnt  <= nextMax;
      maxBin  <= nextMaxBin;
      unique case (state)
        IDLE: if (start) begin
          pixel <= '0;
          bin   <= '0;
        end
        SCAN: bin <= bin + BIN_W'(1);
        LAST: begin
          peakPixel  <= pixel;
          peakBin    <= nextMaxBin;
          peakCounts <= nextMax;
        end
        PRESENT: if (peakReady && !lastPix) begin
          pixel <= pixel + PIX_W'(1);
          bin   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rEnable   = (state == SCAN);
  assign raddr     = rEnable ? scanAddr : '0;
  assign wEnable   = CLEAR_EN && rdValid;
  assign waddr     = wEnable ? rdAddr : '0;
  assign wdata     = '0;
  assign busy      = (state == SCAN) || (state == LAST)
                  || (state == PRESENT);
  assign peakValid = (state == PRESENT);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_his_peak_reader.sv
// Directed bench for his_peak_reader with a behavioural RAM and a
// result/clear monitor.
module tb_his_peak_reader;

  localparam int AW = 7;

  logic       clk = 1'b0;
  logic       res, start, peakReady;
  logic [6:0] raddr, waddr;
  logic       rEnable, wEnable, busy, peakValid, done;
  logic [7:0] rdata, wdata, peakCounts;
  logic [1:0] peakPixel;
  logic [4:0] peakBin;

  his_peak_reader dut (
    .clk(clk), .res(res), .start(start),
    .raddr(raddr), .rEnable(rEnable), .rdata(rdata),
    .waddr(waddr), .wEnable(wEnable), .wdata(wdata),
    .busy(busy), .peakValid(peakValid),
    .peakReady(peakReady), .peakPixel(peakPixel),
    .peakBin(peakBin), .peakCounts(peakCounts),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [0:127];
  logic       ldEn = 1'b0;
  logic [6:0] ldAddr = '0;
  logic [7:0] ldData = '0;

  always @(posedge clk) begin
    if (rEnable) rdata <= ram[raddr];
    if (ldEn) ram[ldAddr] <= ldData;
    else if (wEnable) ram[waddr] <= wdata;
  end

  int resCnt = 0, doneCnt = 0, doneCyc = 0;
  int wCnt = 0, wOrdErr = 0, wBase = 0;
  int resPix [16];
  int resBin [16];
  int resVal [16];
  int resCyc [16];

  always @(negedge clk) begin
    if (peakValid && peakReady) begin
      resPix[resCnt % 16] = int'(peakPixel);
      resBin[resCnt % 16] = int'(peakBin);
      resVal[resCnt % 16] = int'(peakCounts);
      resCyc[resCnt % 16] = cyc;
      resCnt++;
    end
    if (done) begin
      doneCnt++;
      doneCyc = cyc;
    end
    if (wEnable) begin
      if (waddr !== AW'(wCnt - wBase)) wOrdErr++;
      wCnt++;
    end
  end

  int nVec = 0, nFail = 0;
  int startCyc = 0, rB = 0, dB = 0, eB = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int a, int d);
    ldAddr = 7'(a);
    ldData = 8'(d);
    ldEn = 1'b1;
    tick();
    ldEn = 1'b0;
  endtask

  task automatic zeroRam();
    for (int a = 0; a < 128; a++) load(a, 0);
  endtask

  task automatic doStart();
    start = 1'b1;
    startCyc = cyc;
    rB = resCnt;
    dB = doneCnt;
    eB = wOrdErr;
    wBase = wCnt;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(int budget);
    int n = 0;
    while (doneCnt == dB && n < budget) begin
      tick();
      n++;
    end
    chk("done pulse", 64'(doneCnt - dB), 64'd1);
  endtask

  task automatic chkClear(string nm);
    int nz = 0;
    for (int a = 0; a < 128; a++)
      if (ram[a] !== 8'd0) nz++;
    chk({nm, " nonzero bins"}, 64'(nz), 64'd0);
    chk({nm, " write count"}, 64'(wCnt - wBase), 64'd128);
    chk({nm, " write order"}, 64'(wOrdErr - eB), 64'd0);
  endtask

  function automatic logic [63:0] allOut();
    return {22'd0, busy, peakValid, done, rEnable,
            wEnable, raddr, waddr, wdata, peakPixel,
            peakBin, peakCounts};
  endfunction

  typedef struct {
    int pix;
    int b0, b1, b2;
    int v0, v1, v2;
    int eBin, eCnt;
  } vec_t;

  vec_t vecs [8];
  int   model [128];

  initial begin
    vecs[0] = '{0, 5, 5, 5, 9, 9, 9, 5, 9};
    vecs[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{2, 3, 20, 10, 200, 200, 199, 3, 200};
    vecs[3] = '{3, 31, 0, 1, 255, 254, 254, 31, 255};
    vecs[4] = '{0, 0, 1, 2, 7, 7, 3, 0, 7};
    vecs[5] = '{1, 31, 31, 31, 1, 1, 1, 31, 1};
    vecs[6] = '{2, 8, 9, 10, 50, 51, 51, 9, 51};
    vecs[7] = '{3, 16, 17, 0, 128, 127, 1, 16, 128};

    res = 1'b1;
    start = 1'b0;
    peakReady = 1'b1;
    tick();
    tick();
    chk("reset outputs", allOut(), 64'd0);
    res = 1'b0;
    tick();

    for (int s = 0; s < 2; s++) begin
      zeroRam();
      for (int p = 0; p < 4; p++) begin
        vec_t v;
        v = vecs[4*s + p];
        load(v.pix*32 + v.b0, v.v0);
        load(v.pix*32 + v.b1, v.v1);
        load(v.pix*32 + v.b2, v.v2);
      end
      doStart();
      waitDone(300);
      chk("result count", 64'(resCnt - rB), 64'd4);
      for (int p = 0; p < 4; p++) begin
        vec_t v;
        int i;
        v = vecs[4*s + p];
        i = (rB + p) % 16;
        chk("vec pixel", 64'(resPix[i]), 64'(v.pix));
        chk("vec bin", 64'(resBin[i]), 64'(v.eBin));
        chk("vec count", 64'(resVal[i]), 64'(v.eCnt));
      end
      if (s == 0) begin
        chk("first result cycle",
            64'(resCyc[rB % 16] - startCyc), 64'd34);
        chk("done cycle", 64'(doneCyc - startCyc), 64'd137);
      end
      chkClear("table scan");
    end

    for (int a = 0; a < 128; a++) begin
      model[a] = int'($urandom_range(0, 31));
      load(a, model[a]);
    end
    doStart();
    waitDone(300);
    chk("random count", 64'(resCnt - rB), 64'd4);
    for (int p = 0; p < 4; p++) begin
      int mb, mv, i;
      mb = 0;
      mv = model[p*32];
      for (int b = 1; b < 32; b++)
        if (model[p*32 + b] > mv) begin
          mv = model[p*32 + b];
          mb = b;
        end
      i = (rB + p) % 16;
      chk("random bin", 64'(resBin[i]), 64'(mb));
      chk("random count val", 64'(resVal[i]), 64'(mv));
    end
    chkClear("random scan");

    zeroRam();
    load(32 + 7, 42);
    doStart();
    begin
      int n = 0;
      while (!(peakValid && peakPixel == 2'd0) && n < 100) begin
        tick();
        n++;
      end
      chk("stall pixel0 seen", 64'(peakValid), 64'd1);
      tick();
      peakReady = 1'b0;
      n = 0;
      while (!peakValid && n < 100) begin
        tick();
        n++;
      end
      for (int k = 0; k < 10; k++) begin
        chk("stall hold",
            {peakValid, peakPixel, peakBin, peakCounts,
             rEnable, wEnable},
            {1'b1, 2'd1, 5'd7, 8'd42, 1'b0, 1'b0});
        tick();
      end
      peakReady = 1'b1;
      tick();
      chk("resume read", {rEnable, raddr}, {1'b1, 7'd64});
      waitDone(300);
      chk("stall result count", 64'(resCnt - rB), 64'd4);
    end

    zeroRam();
    load(96 + 2, 3);
    doStart();
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(300);
    repeat (40) tick();
    chk("restart results", 64'(resCnt - rB), 64'd4);
    chk("restart dones", 64'(doneCnt - dB), 64'd1);
    chk("restart idle busy", 64'(busy), 64'd0);
    chk("restart pixel3 bin", 64'(resBin[(rB + 3) % 16]), 64'd2);
    chk("restart pixel3 cnt", 64'(resVal[(rB + 3) % 16]), 64'd3);

    doStart();
    repeat (49) tick();
    res = 1'b1;
    tick();
    chk("mid-scan reset outputs", allOut(), 64'd0);
    res = 1'b0;
    repeat (5) tick();
    chk("after reset idle",
        {busy, rEnable, wEnable, peakValid}, 64'd0);
    chk("no done after reset", 64'(doneCnt - dB), 64'd0);
    doStart();
    begin
      int n = 0;
      while (resCnt == rB && n < 100) begin
        tick();
        n++;
      end
    end
    chk("fresh scan latency",
        64'(resCyc[rB % 16] - startCyc), 64'd34);
    chk("fresh scan pixel", 64'(resPix[rB % 16]), 64'd0);
    waitDone(300);

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nFail);
    $finish;
  end

endmodule
